ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares one synchronous single-clock RAM (one read port, one write port, 1-cycle registered read, 2**multWidth words of dataWidth bits) between two requesters.
- Typical use: port 0 = instruction fetch, port 1 = load/store.
- Arbitration is round-robin on conflict. A read and a write from different ports issue in the same cycle.
- Returns read data with a fixed 1-cycle latency and a per-port valid strobe.

Parameters:
- dataWidth, 32, data word width; must match the RAM instance.
- multWidth, 4, address width; the RAM depth is 2**multWidth.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  request valid, port 0 / port 1.
- we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  input  multWidth each  word address.
- wdata0, wdata1  input  dataWidth each  write data.
- gnt0, gnt1  output  1 each  combinational accept; the request is consumed on the edge where reqN && gntN.
- rvalid0, rvalid1  output  1 each  registered; read data for portN is valid this cycle.
- rdata0, rdata1  output  dataWidth each  read data; equals ramOut; meaningful only while rvalidN = 1.
- ramReadAddress  output  multWidth  to the RAM read address.
- ramWriteAddress  output  multWidth  to the RAM write address.
- ramWrite  output  1  to the RAM write enable.
- ramIn  output  dataWidth  to the RAM write data.
- ramOut  input  dataWidth  from the RAM registered read data.

Behaviour:
- State:
  - prio: 1-bit round-robin pointer; 0 means port 0 wins the next conflict.
  - rvalid0_q, rvalid1_q: read-return flags.
- Reset (resetn low, asynchronous): prio = 0, rvalid0 = rvalid1 = 0. Combinational outputs follow their inputs immediately.
- Request handshake:
  - A requester raises reqN and holds reqN, weN, addrN and wdataN stable until the cycle in which gntN = 1.
  - It may drop reqN or present a new request in the cycle after the grant.
  - gntN is never 1 while reqN = 0.
- Grant decode, combinational, per cycle:
  - Only one port requests: that port is granted.
  - Both request with different weN (one read, one write): both are granted; the read drives ramReadAddress and the write drives ramWriteAddress/ramIn with ramWrite = 1. prio is unchanged.
  - Both request with the same weN (conflict): the port selected by prio is granted. On the edge, prio flips to the loser's index.
  - No grant to a writer: ramWrite = 0. ramWriteAddress and ramIn are don't-care but must not be X; drive 0.
  - No grant to a reader: ramReadAddress holds 0. The RAM still reads; the result is ignored.
- Read return:
  - A granted read from port N in cycle T sets rvalidN = 1 in cycle T+1 only.
  - rdataN = ramOut, zero added latency beyond the RAM's one register.
  - Back-to-back granted reads give back-to-back rvalid pulses.
- Write latency: the write lands at the edge ending the grant cycle. A read of the same address granted in cycle T+1 or later returns the new data.
- Same-cycle read and write to the same address (dual issue): the read returns the OLD word, matching the RAM's read-before-write behaviour. This is documented, not hazard-protected.
- Fairness: under continuous conflicting requests, grants alternate strictly 0,1,0,1. Neither port waits more than 1 cycle.
- Reset mid-operation: a read granted in the cycle reset asserts never produces an rvalid. After reset release, the first conflict goes to port 0.
- Widths: no arithmetic. All data and address paths are pass-through at the declared widths.

Test Plan:
1. Reset, then port 0 writes 0xDEADBEEF to addr 3, then reads addr 3 -> gnt0 = 1 on each request cycle; rvalid0 = 1 one cycle after the read grant with rdata0 = 0xDEADBEEF; rvalid1 stays 0.
2. Both ports read (addr0 = 1, addr1 = 2) every cycle for 6 cycles -> grants alternate starting with port 0; each rvalid pulse appears exactly 1 cycle after its grant with the correct word.
3. Port 0 reads addr 5 while port 1 writes 0x12345678 to addr 5 in the same cycle -> both granted; rdata0 = old mem[5]; a later port 0 read of addr 5 returns 0x12345678; prio unchanged.
4. Both ports write different values to addr 7 continuously for 4 cycles -> alternating grants; mem[7] equals the last granted writer's data; ramWrite is high every cycle.
5. Port 1 read granted, then resetn pulsed low before the next edge -> rvalid1 never asserts; after release, a 0-vs-1 read conflict grants port 0.
6. Idle ports, then a single port 1 request held for 3 cycles with gnt1 = 1 each cycle -> three accepted transactions; gnt0 = 0 throughout; ramWrite = 0 whenever no write is granted.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-clock RAM with one read and one write port.
// A read and a write from different ports dual-issue; same-kind conflicts go round-robin.
module ram_port_arbiter #(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned multWidth = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [multWidth-1:0] addr0,
    input  logic [multWidth-1:0] addr1,
    input  logic [dataWidth-1:0] wdata0,
    input  logic [dataWidth-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [dataWidth-1:0] rdata0,
    output logic [dataWidth-1:0] rdata1,
    output logic [multWidth-1:0] ramReadAddress,
    output logic [multWidth-1:0] ramWriteAddress,
    output logic                 ramWrite,
    output logic [dataWidth-1:0] ramIn,
    input  logic [dataWidth-1:0] ramOut
);

    logic prio_q, prio_d;
    logic rvalid0_q, rvalid1_q;
    logic conflict;
    logic rd0, rd1, wr0, wr1;

    always_comb begin
        // Conflict only when both want the same RAM port; read+write dual-issue
        conflict = req0 && req1 && (we0 == we1);
        gnt0     = req0 && (!conflict || !prio_q);
        gnt1     = req1 && (!conflict || prio_q);

        rd0 = gnt0 && !we0;
        rd1 = gnt1 && !we1;
        wr0 = gnt0 && we0;
        wr1 = gnt1 && we1;

        ramReadAddress = '0;
        if (rd0) begin
            ramReadAddress = addr0;
        end else if (rd1) begin
            ramReadAddress = addr1;
        end

        ramWrite        = wr0 || wr1;
        ramWriteAddress = '0;
        ramIn           = '0;
        if (wr0) begin
            ramWriteAddress = addr0;
            ramIn           = wdata0;
        end else if (wr1) begin
            ramWriteAddress = addr1;
            ramIn           = wdata1;
        end

        // The winner of a conflict hands priority to the loser
        prio_d = conflict ? ~prio_q : prio_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = ramOut;
    assign rdata1  = ramOut;

endmodule
